// File: rtl/inst_mem_loader.sv
// ----------------------------------------------------------------------------
// inst_mem_loader
//
// Programming-side writer for the byte-wide instruction memory. Bytes arrive
// from the I2C byte-level slave. Each frame has the form
// {start address, length, data...}. The loader issues one single-cycle byte
// write (address/data/cs) per data byte. It holds the core off the memory
// for as long as a frame is in progress.
//
// State table (state | meaning)
//   IDLE  | no frame in progress; waits for i_frame_start, drops bytes
//   ADDR  | waits for the start-address byte
//   LEN   | waits for the length byte (0 means the full memory)
//   DATA  | waits for the next data byte
//   WRITE | o_cs asserted for exactly one cycle; ptr/count/checksum advance
//
// Ports
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_frame_start        1-cycle pulse: I2C START addressed to the loader
//   i_frame_end          1-cycle pulse: I2C STOP
//   i_rx_byte/i_rx_valid received byte; consumed when i_rx_valid & o_rx_ready
//   o_rx_ready           loader accepts a byte this cycle (ADDR/LEN/DATA)
//   o_address/o_data/o_cs  memory write port, o_cs high one cycle per byte
//   o_cpu_hold           high while a frame is in progress
//   o_done               1-cycle pulse after the final byte of a frame is written
//   o_err                sticky: frame ended or restarted early
//   o_checksum           modular sum of the data bytes written in this frame
// ----------------------------------------------------------------------------
module inst_mem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_frame_start,
    input  logic              i_frame_end,
    input  logic [DATA_W-1:0] i_rx_byte,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_data,
    output logic              o_cs,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_err,
    output logic [DATA_W-1:0] o_checksum
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1) << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        LEN   = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                cs_q, cs_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   checksum_q, checksum_d;
    logic                pend_start_q, pend_start_d;
    logic                pend_end_q, pend_end_d;

    logic                rx_ready;
    logic                accept;
    logic                ev_start;
    logic                ev_end;

    assign rx_ready = (state_q == ADDR) || (state_q == LEN) || (state_q == DATA);
    assign accept   = i_rx_valid && rx_ready;

    // Events seen during WRITE are replayed in the cycle after it, together
    // with whatever arrives live in that cycle.
    assign ev_start = i_frame_start || pend_start_q;
    assign ev_end   = i_frame_end   || pend_end_q;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        count_d      = count_q;
        address_d    = address_q;
        data_d       = data_q;
        cs_d         = 1'b0;
        done_d       = 1'b0;
        err_d        = err_q;
        checksum_d   = checksum_q;
        pend_start_d = 1'b0;
        pend_end_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (ev_start) begin
                    state_d    = ADDR;
                    err_d      = 1'b0;
                    checksum_d = '0;
                end
            end

            ADDR, LEN, DATA: begin
                if (ev_start) begin
                    // Restart abandons the current frame but keeps the
                    // loader busy for the new one.
                    state_d    = ADDR;
                    err_d      = 1'b1;
                    checksum_d = '0;
                end else if (ev_end) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (accept) begin
                    case (state_q)
                        ADDR: begin
                            ptr_d   = ADDR_W'(i_rx_byte);
                            state_d = LEN;
                        end
                        LEN: begin
                            count_d = (i_rx_byte == '0) ? CNT_FULL : CNT_W'(i_rx_byte);
                            state_d = DATA;
                        end
                        default: begin
                            data_d    = i_rx_byte;
                            address_d = ptr_q;
                            cs_d      = 1'b1;
                            state_d   = WRITE;
                        end
                    endcase
                end
            end

            WRITE: begin
                pend_start_d = pend_start_q || i_frame_start;
                pend_end_d   = pend_end_q   || i_frame_end;
                ptr_d        = ptr_q + ADDR_W'(1);
                count_d      = count_q - CNT_ONE;
                checksum_d   = checksum_q + data_q;
                if (count_q == CNT_ONE) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = DATA;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        hold_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            count_q      <= '0;
            address_q    <= '0;
            data_q       <= '0;
            cs_q         <= 1'b0;
            hold_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            checksum_q   <= '0;
            pend_start_q <= 1'b0;
            pend_end_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            count_q      <= count_d;
            address_q    <= address_d;
            data_q       <= data_d;
            cs_q         <= cs_d;
            hold_q       <= hold_d;
            done_q       <= done_d;
            err_q        <= err_d;
            checksum_q   <= checksum_d;
            pend_start_q <= pend_start_d;
            pend_end_q   <= pend_end_d;
        end
    end

    assign o_rx_ready = rx_ready;
    assign o_address  = address_q;
    assign o_data     = data_q;
    assign o_cs       = cs_q;
    assign o_cpu_hold = hold_q;
    assign o_done     = done_q;
    assign o_err      = err_q;
    assign o_checksum = checksum_q;

endmodule
